// File: rtl/dcache_data_array_responder_if.sv
// Request/response channel between the DCache data-array arbiter (master)
// and the data-array responder (slave).
//   req_*  : arbitrated single request (addr/write/wdata/eccMask/way_en)
//   resp_* : held read response carrying all ways of the addressed row
interface dcache_data_array_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int WAYS   = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_W-1:0]      req_addr;
  logic                   req_write;
  logic [DATA_W-1:0]      req_wdata;
  logic [DATA_W/8-1:0]    req_eccMask;
  logic [WAYS-1:0]        req_way_en;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WAYS*DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0]      resp_addr;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_eccMask, req_way_en, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_addr
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_eccMask, req_way_en, resp_ready,
    output req_ready, resp_valid, resp_data, resp_addr
  );
endinterface

// File: rtl/dcache_data_array_responder.sv
// Responder side of the DCache data-array request channel. Performs the
// arbitrated request on a WAYS-wide behavioural data array: writes are
// byte-masked per enabled way, reads return every way of the row one cycle
// later through a held response register with valid/ready backpressure.
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous active-low reset
//   bus (slave)        req_valid/req_ready/req_addr/req_write/req_wdata/
//                      req_eccMask/req_way_en, resp_valid/resp_ready/
//                      resp_data/resp_addr
//   inject_parity_flip (DCACHE_DATA_PARITY_EN only) invert stored parity of
//                      the bytes written by this request
//   resp_parity_err    (DCACHE_DATA_PARITY_EN only) per-way parity error,
//                      loaded and held together with resp_data
//
// Optional feature macro: DCACHE_DATA_PARITY_EN (per-byte even parity).
module dcache_data_array_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int WAYS   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef DCACHE_DATA_PARITY_EN
  input  logic                 inject_parity_flip,
  output logic [WAYS-1:0]      resp_parity_err,
`endif
  dcache_data_array_responder_if.slave bus
);

  localparam int ROW_W = ADDR_W - 3;
  localparam int ROWS  = 1 << ROW_W;
  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0]      mem [WAYS][ROWS];
  logic [ROW_W-1:0]       row;
  logic                   accept;
  logic                   rd_accept;
  logic                   wr_accept;
  logic [WAYS*DATA_W-1:0] rd_data;
  logic                   resp_valid_q;
  logic [WAYS*DATA_W-1:0] resp_data_q;
  logic [ADDR_W-1:0]      resp_addr_q;
  logic                   unused_addr_lsb;

  // Byte offset within a row plays no part in addressing.
  assign unused_addr_lsb = ^bus.req_addr[2:0];
  assign row             = bus.req_addr[ADDR_W-1:3];

  // A held response blocks every request type: single port, strict order.
  assign bus.req_ready = ~resp_valid_q | bus.resp_ready;
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_accept     = accept & ~bus.req_write;
  assign wr_accept     = accept & bus.req_write;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_addr  = resp_addr_q;

  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_data[w*DATA_W +: DATA_W] = mem[w][row];
    end
  end

`ifdef DCACHE_DATA_PARITY_EN
  logic [BYTES-1:0] par_mem [WAYS][ROWS];
  logic [WAYS-1:0]  rd_perr;
  logic [WAYS-1:0]  resp_perr_q;

  // Stored bit is the XOR of the byte, so byte plus parity has even weight.
  always_comb begin
    rd_perr = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        rd_perr[w] = rd_perr[w] | ((^mem[w][row][b*8 +: 8]) ^ par_mem[w][row][b]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.req_way_en[w] && bus.req_eccMask[b]) begin
            par_mem[w][row][b] <= (^bus.req_wdata[b*8 +: 8]) ^ inject_parity_flip;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_perr_q <= '0;
    end else if (rd_accept) begin
      resp_perr_q <= rd_perr;
    end
  end

  assign resp_parity_err = resp_perr_q;
`endif

  // Array contents are intentionally left unreset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.req_way_en[w] && bus.req_eccMask[b]) begin
            mem[w][row][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // resp_data keeps its last value after the handshake; only valid drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
    end else if (rd_accept) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= rd_data;
      resp_addr_q  <= bus.req_addr;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

endmodule
